// File: rtl/xalu_muldiv_pkg.sv
// Shared XALU_Op encodings and types for the main decoder and the HI/LO
// multiply/divide unit.
package xalu_muldiv_pkg;

    localparam logic [2:0] XOP_NONE  = 3'b000;
    localparam logic [2:0] XOP_MF    = 3'b001;
    localparam logic [2:0] XOP_MTLO  = 3'b010;
    localparam logic [2:0] XOP_MTHI  = 3'b011;
    localparam logic [2:0] XOP_DIV   = 3'b100;
    localparam logic [2:0] XOP_DIVU  = 3'b101;
    localparam logic [2:0] XOP_MULT  = 3'b110;
    localparam logic [2:0] XOP_MULTU = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } xalu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/xalu_compute.sv
// Combinational mult/multu/div/divu datapath producing the full {hi,lo}
// result and a divide-by-zero flag for the commit logic.
module xalu_compute
    import xalu_muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       res,
    output logic        div_by_zero
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] abs_a, abs_b, dvd, dvs, uq, ur;

    always_comb begin
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'b0, a} * {32'b0, b};

        // Signed divide goes through magnitudes so the INT_MIN / -1 case
        // wraps to 0x80000000 instead of relying on signed overflow.
        abs_a = a[31] ? (32'd0 - a) : a;
        abs_b = b[31] ? (32'd0 - b) : b;
        dvd   = (op == XOP_DIV) ? abs_a : a;
        dvs   = (op == XOP_DIV) ? abs_b : b;
        if (dvs == 32'd0) dvs = 32'd1;
        uq = dvd / dvs;
        ur = dvd % dvs;

        div_by_zero = op[2] & ~op[1] & (b == 32'd0);

        res = '0;
        case (op)
            XOP_MULT:  res = hilo_t'(sprod);
            XOP_MULTU: res = hilo_t'(uprod);
            XOP_DIV: begin
                res.lo = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
                res.hi = a[31] ? (32'd0 - ur) : ur;
            end
            XOP_DIVU: begin
                res.lo = uq;
                res.hi = ur;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/xalu_muldiv.sv
// E-stage multiply/divide unit owning HI/LO; result is latched at start and
// committed after a fixed busy latency so the hazard unit can stall on Busy.
module xalu_muldiv
    import xalu_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  XALU_Op,
    input  logic        XALU_Src,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] XALU_Out,
    output logic        Start,
    output logic        Busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    xalu_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    hilo_t         hilo, hilo_n, pend, pend_n, res;
    logic          pend_dz, pend_dz_n, dz;

    xalu_compute u_compute (
        .op          (XALU_Op),
        .a           (A),
        .b           (B),
        .res         (res),
        .div_by_zero (dz)
    );

    assign Busy     = (state == ST_BUSY);
    assign Start    = XALU_Op[2] & ~Busy;
    assign XALU_Out = XALU_Src ? hilo.hi : hilo.lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hilo    <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hilo    <= hilo_n;
            pend    <= pend_n;
            pend_dz <= pend_dz_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hilo_n    = hilo;
        pend_n    = pend;
        pend_dz_n = pend_dz;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    pend_n    = res;
                    pend_dz_n = dz;
                    cnt_n     = XALU_Op[1] ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_n   = ST_BUSY;
                end else if (XALU_Op == XOP_MTLO) begin
                    hilo_n.lo = A;
                end else if (XALU_Op == XOP_MTHI) begin
                    hilo_n.hi = A;
                end
            end
            ST_BUSY: begin
                // Writes other than the commit are ignored while busy.
                if (cnt == CW'(1)) begin
                    if (!pend_dz) hilo_n = pend;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_xalu_muldiv.sv
// Directed bench for xalu_muldiv: a cycle-level HI/LO model checked every
// cycle, plus literal expectations for each directed vector.
module tb_xalu_muldiv;

    localparam logic [2:0] OP_NONE = 3'b000, OP_MTLO = 3'b010, OP_MTHI = 3'b011,
                           OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_MULT = 3'b110,
                           OP_MULTU = 3'b111;
    localparam int MC = 5, DC = 10;

    logic        clk = 1'b0, reset;
    logic [2:0]  XALU_Op;
    logic        XALU_Src;
    logic [31:0] A, B, XALU_Out;
    logic        Start, Busy;

    int n_tests = 0, n_fail = 0;

    xalu_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .XALU_Op(XALU_Op), .XALU_Src(XALU_Src),
        .A(A), .B(B), .XALU_Out(XALU_Out), .Start(Start), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pdz;
    int          m_left;
    longint      sp;
    longint unsigned up;
    int          sa, sb, q, r;
    int unsigned ua, ub;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pdz = 0; m_left = 0;
        end else if (m_left > 0) begin
            if (m_left == 1 && !m_pdz) begin
                m_hi = m_phi; m_lo = m_plo;
            end
            m_left--;
        end else if (XALU_Op[2]) begin
            sa = A; sb = B; ua = A; ub = B; m_pdz = 0;
            case (XALU_Op)
                OP_MULT: begin
                    sp = longint'(sa) * longint'(sb);
                    m_phi = sp[63:32]; m_plo = sp[31:0];
                end
                OP_MULTU: begin
                    up = longint'({32'b0, A}) * longint'({32'b0, B});
                    m_phi = up[63:32]; m_plo = up[31:0];
                end
                OP_DIV: begin
                    if (sb == 0) m_pdz = 1;
                    else if (sa == 32'sh8000_0000 && sb == -1) begin
                        m_plo = 32'h8000_0000; m_phi = 0;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        m_plo = q; m_phi = r;
                    end
                end
                default: begin
                    if (ub == 0) m_pdz = 1;
                    else begin
                        m_plo = ua / ub; m_phi = ua % ub;
                    end
                end
            endcase
            m_left = XALU_Op[1] ? MC : DC;
        end else if (XALU_Op == OP_MTLO) m_lo = A;
        else if (XALU_Op == OP_MTHI) m_hi = A;
    end

    always @(negedge clk) begin
        chk("model_busy", {31'b0, Busy}, {31'b0, m_left > 0});
        chk("model_start", {31'b0, Start}, {31'b0, XALU_Op[2] && m_left == 0});
        chk("model_out", XALU_Out, XALU_Src ? m_hi : m_lo);
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic src, output logic [31:0] v);
        XALU_Src = src; #1; v = XALU_Out;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start);
        XALU_Op = op; A = a; B = b; #1;
        chk("start", {31'b0, Start}, {31'b0, exp_start});
        nxt();
        XALU_Op = OP_NONE;
    endtask

    task automatic wait_idle(input string name, input int exp_n);
        int n = 0;
        while (Busy && n < 40) begin nxt(); n++; end
        chk(name, n, exp_n);
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] v;
        rd(1'b1, v); chk({name, "_hi"}, v, eh);
        rd(1'b0, v); chk({name, "_lo"}, v, el);
    endtask

    logic [31:0] v;

    initial begin
        reset = 1; XALU_Op = OP_NONE; XALU_Src = 0; A = 0; B = 0;
        nxt(); nxt();
        chk_hilo("reset", 0, 0);
        chk("reset_busy", {31'b0, Busy}, 0);
        reset = 0;
        nxt();

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1);
        wait_idle("mult_cycles", 5);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        nxt();

        issue(OP_MTLO, 32'h0000_5555, 0, 0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1);
        rd(1'b0, v); chk("multu_busy_lo", v, 32'h0000_5555);
        wait_idle("multu_cycles", 5);
        chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        nxt();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        wait_idle("div_cycles", 10);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        nxt();
        issue(OP_DIVU, 32'd7, 32'd2, 1);
        wait_idle("divu_cycles", 10);
        chk_hilo("divu", 32'd1, 32'd3);
        nxt();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_idle("div_ovf_cycles", 10);
        chk_hilo("div_ovf", 32'd0, 32'h8000_0000);
        nxt();

        issue(OP_MTHI, 32'h1234_5678, 0, 0);
        rd(1'b1, v); chk("mthi", v, 32'h1234_5678);
        nxt();
        issue(OP_DIVU, 32'd99, 32'd0, 1);
        wait_idle("divz_cycles", 10);
        chk_hilo("divz", 32'h1234_5678, 32'h8000_0000);
        nxt();

        issue(OP_MULT, 32'd3, 32'd5, 1);
        XALU_Op = OP_MTLO; A = 32'h0000_AAAA; #1;
        chk("busy_mtlo_start", {31'b0, Start}, 0);
        nxt();
        XALU_Op = OP_MULT; A = 32'd7; B = 32'd7; #1;
        chk("busy_mult_start", {31'b0, Start}, 0);
        nxt();
        XALU_Op = OP_NONE;
        wait_idle("busy_ign_cycles", 3);
        chk_hilo("busy_ign", 32'd0, 32'd15);
        nxt();

        issue(OP_MULT, 32'd6, 32'd7, 1);
        nxt(); nxt();
        reset = 1; #1;
        chk("rst_mid_busy", {31'b0, Busy}, 0);
        chk_hilo("rst_mid", 0, 0);
        nxt();
        reset = 0;
        repeat (8) nxt();
        chk("rst_after_busy", {31'b0, Busy}, 0);
        chk_hilo("rst_after", 0, 0);

        nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
Execute-stage multiply/divide unit owning the HI/LO registers; consumes the XALU_Op/XALU_Src control produced by the decode-stage main decoder and the E-stage operands.
- Models multi-cycle latency with a busy counter so the hazard unit can stall later HI/LO users.
- Result of mfhi/mflo is returned combinationally for the E-stage result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
XALU_Op  input  3  E-stage op: 000 none, 001 move-from, 010 mtlo, 011 mthi, 100 div, 101 divu, 110 mult, 111 multu
XALU_Src  input  1  move-from select: 1 = HI, 0 = LO
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
XALU_Out  output  32  XALU_Src ? HI : LO, combinational
Start  output  1  combinational; high when XALU_Op[2]=1 and Busy=0
Busy  output  1  registered; high while an operation is in flight

Behaviour:
- Reset, asynchronous: HI=0, LO=0, Busy=0, counter=0, pending result=0. XALU_Out then reads 0.
- Start takes effect when XALU_Op[2]=1 and Busy=0 in cycle N. At that edge the unit:
  - computes and latches the 64-bit result into pending {hi,lo};
  - loads the counter with MULT_CYCLES or DIV_CYCLES;
  - sets Busy.
- Busy is high for cycles N+1 .. N+k (k = selected cycle count).
- The counter decrements each busy cycle. On the edge ending cycle N+k, with counter==1:
  - pending is committed to HI/LO and Busy clears;
  - HI/LO are readable by a move-from in cycle N+k+1.
- HI/LO must not change before that commit edge; XALU_Out shows old values throughout Busy.
- mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0]. multu: unsigned.
- div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0, div or divu): the op still occupies DIV_CYCLES of Busy, but the commit leaves HI/LO unchanged.
- mthi/mtlo write A into HI/LO at the clock edge when Busy=0; the value is readable the next cycle.
- Any op other than none/move-from is ignored while Busy=1: no Start, no HI/LO write, no counter change.
  - The hazard unit must stall so this never happens; the block still defines it.
- A move-from while Busy=1 returns the current (old) HI/LO; stalling it is the hazard unit's job.
- Busy and Start are never simultaneously high.
- Reset mid-operation: everything clears immediately; the aborted result is never committed.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Decomposition:
- Shared package holds localparams for the XALU_Op encodings: XOP_NONE, XOP_MF, XOP_MTLO, XOP_MTHI, XOP_DIV, XOP_DIVU, XOP_MULT, XOP_MULTU.
  - The main decoder and this block both use the package.
- One combinational sub-module, xalu_compute (op, A, B -> 64-bit {hi,lo} plus div_by_zero flag), keeps the arithmetic separate from the counter/commit FSM.

Test Plan:
- mult, A=0xFFFFFFFF, B=2 -> Start=1 in cycle N; Busy=1 for exactly 5 cycles; next cycle mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE.
- multu, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; mflo during Busy still returns the prior LO.
- div, A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu, A=7, B=2 -> LO=3, HI=1; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678 then next cycle mfhi -> 0x12345678; divu with B=0 -> Busy for 10 cycles, HI/LO unchanged afterwards.
- During Busy, issue mtlo 0xAAAA and a second mult -> both ignored, Start=0, Busy count and final result those of the first op.
- Assert reset in the 3rd busy cycle of a mult -> Busy=0 and HI=LO=0 immediately; no commit occurs after reset is released.
